copper_list_sequencer: RTL and testbench
========================================

Name: copper_list_sequencer

Overview:
- Per-frame display-list executor ("copper") that schedules register writes into the display datapath at chosen beam positions.
- Reads 32-bit instructions from an external synchronous-read program memory and tracks the beam x/y from video_sync.
- Emits a one-cycle register-write bus that configures the colour, copper and sprite blocks.
- Restarts from address 0 on every vsync_start.

Parameters:
- COORD_WIDTH, 16, width of the signed beam coordinates x/y.
- ADDR_WIDTH, 6, program address width; program depth = 2**ADDR_WIDTH.
- REG_ADDR_WIDTH, 4, target register address width.

Ports:
- pixel_clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run permission; sampled every cycle.
- vsync_start  in  1  one-cycle frame-start pulse from video_sync.
- x  in  COORD_WIDTH  signed beam x.
- y  in  COORD_WIDTH  signed beam y.
- prog_addr  out  ADDR_WIDTH  program memory read address.
- prog_data  in  32  instruction; valid one cycle after prog_addr.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_addr  out  REG_ADDR_WIDTH  target register.
- reg_wr_data  out  24  write value (RGB or coordinate).
- halted  out  1  high in HALT state.

Behaviour:
- Instruction encoding:
  - [31:30] = 00 MOVE: reg_wr_addr = [REG_ADDR_WIDTH+23:24], data = [23:0].
  - 01 WAIT: target y = [27:16], target x = [11:0], both unsigned 12-bit, zero-extended.
  - 10 END.
  - 11 JUMP: new pc = [ADDR_WIDTH-1:0].
- States: HALT, FETCH, EXEC, WAIT.
- Reset:
  - State = HALT, pc = 0, prog_addr = 0.
  - reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0, halted = 1.
- HALT:
  - vsync_start && enable -> FETCH with pc = 0.
  - Otherwise stay in HALT.
- FETCH: drive prog_addr = pc; go to EXEC next cycle.
- EXEC (prog_data valid this cycle):
  - MOVE: on the next edge, reg_wr_en = 1 with addr/data latched; pc = pc+1; -> FETCH. Throughput is one MOVE per 2 cycles.
  - WAIT: latch the target; pc = pc+1; -> WAIT.
  - END: -> HALT; pc unchanged.
  - JUMP: pc = target; -> FETCH.
- WAIT:
  - Condition met when y >= 0 && x >= 0 && (y > ty || (y == ty && x >= tx)).
  - When met -> FETCH. A target already passed completes after one WAIT cycle.
  - Negative coordinates (blanking/back porch) never satisfy the condition.
- Write strobe:
  - reg_wr_en is high for exactly one cycle per MOVE; otherwise 0.
  - reg_wr_addr and reg_wr_data hold their last values when the strobe is low.
- PC arithmetic: pc increments modulo 2**ADDR_WIDTH; pc = 2**ADDR_WIDTH-1 followed by +1 wraps to 0.
- vsync_start in any non-HALT state:
  - Next state = FETCH with pc = 0, if enable is high.
  - Overrides the current instruction. A MOVE in EXEC that same cycle produces no write; a pending WAIT is abandoned.
- enable low in any state: next state = HALT, no write issued. Raising enable does not resume execution; the sequencer waits for the next vsync_start.
- reset mid-frame: all state returns to reset values on the next edge; reset has priority over vsync_start.
- Looping JUMP lists are legal; they run until vsync_start or until enable drops.
- halted = (state == HALT), registered.

Test Plan:
- Reset then idle: reset high for 2 cycles, no vsync -> halted = 1, reg_wr_en = 0, prog_addr = 0 for 100 cycles.
- MOVE sequence: program {MOVE r1 = 0x112255, MOVE r2 = 0x442211, END}, pulse vsync_start -> strobes 2 cycles apart with addr 1 then 2 and exact data; afterwards halted = 1, pc = 2.
- WAIT timing: program {WAIT y = 150 x = 80, MOVE r3 = 0xFFFFFF, END}, drive x/y from video_sync -> write occurs exactly 3 cycles after the beam reaches (80,150); no write while y < 0; WAIT y = 0 x = 0 entered at beam (10,20) completes after 1 WAIT cycle.
- vsync override: vsync_start asserted in the same cycle as a MOVE EXEC -> no strobe that cycle; prog_addr = 0 next cycle; list re-executes from the start.
- Wrap and JUMP: ADDR_WIDTH = 2, four MOVEs with no END -> pc wraps 3 -> 0 and strobes continue. Program {MOVE, JUMP 0} -> a strobe every 4 cycles until vsync_start.
- Enable and reset: enable dropped mid-WAIT -> HALT next cycle; enable restored -> no strobes until the next vsync_start. reset asserted together with vsync_start -> outputs at reset values.

Source files
------------

// File: rtl/copper_list_sequencer.sv
// Per-frame display-list executor: walks a 32-bit instruction list from program
// memory, waits on beam positions and issues one-cycle register writes.
module copper_list_sequencer #(
    parameter int COORD_WIDTH    = 16,
    parameter int ADDR_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                          pixel_clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          vsync_start,
    input  logic signed [COORD_WIDTH-1:0] x,
    input  logic signed [COORD_WIDTH-1:0] y,
    output logic [ADDR_WIDTH-1:0]         prog_addr,
    input  logic [31:0]                   prog_data,
    output logic                          reg_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]     reg_wr_addr,
    output logic [23:0]                   reg_wr_data,
    output logic                          halted
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_END  = 2'b10;
    localparam logic [1:0] OP_JUMP = 2'b11;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [COORD_WIDTH-1:0]  tgt_x;
    logic [COORD_WIDTH-1:0]  tgt_y;
    logic                    wait_met;
    logic                    unused_bits;

    // The memory registers the address, so presenting pc directly gives data in EXEC.
    assign prog_addr = pc;

    assign unused_bits = ^prog_data[29:28];

    function automatic logic beam_reached(
        input logic signed [COORD_WIDTH-1:0] bx,
        input logic signed [COORD_WIDTH-1:0] by,
        input logic [COORD_WIDTH-1:0]        tx,
        input logic [COORD_WIDTH-1:0]        ty
    );
        logic [COORD_WIDTH-1:0] ux;
        logic [COORD_WIDTH-1:0] uy;
        ux = $unsigned(bx);
        uy = $unsigned(by);
        // Negative coordinates are blanking and never count as reached.
        beam_reached = !bx[COORD_WIDTH-1] && !by[COORD_WIDTH-1] &&
                       ((uy > ty) || ((uy == ty) && (ux >= tx)));
    endfunction

    assign wait_met = beam_reached(x, y, tgt_x, tgt_y);

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state       <= ST_HALT;
            pc          <= '0;
            tgt_x       <= '0;
            tgt_y       <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            halted      <= 1'b1;
        end else begin
            reg_wr_en <= 1'b0;
            if (!enable) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end else if (vsync_start) begin
                // Frame start restarts the list and overrides whatever is in flight.
                state  <= ST_FETCH;
                pc     <= '0;
                halted <= 1'b0;
            end else begin
                case (state)
                    ST_HALT: begin
                        halted <= 1'b1;
                    end
                    ST_FETCH: begin
                        state  <= ST_EXEC;
                        halted <= 1'b0;
                    end
                    ST_EXEC: begin
                        case (prog_data[31:30])
                            OP_MOVE: begin
                                reg_wr_en   <= 1'b1;
                                reg_wr_addr <= prog_data[REG_ADDR_WIDTH+23:24];
                                reg_wr_data <= prog_data[23:0];
                                pc          <= pc + ADDR_WIDTH'(1);
                                state       <= ST_FETCH;
                                halted      <= 1'b0;
                            end
                            OP_WAIT: begin
                                tgt_y  <= COORD_WIDTH'(prog_data[27:16]);
                                tgt_x  <= COORD_WIDTH'(prog_data[11:0]);
                                pc     <= pc + ADDR_WIDTH'(1);
                                state  <= ST_WAIT;
                                halted <= 1'b0;
                            end
                            OP_END: begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                            OP_JUMP: begin
                                pc     <= prog_data[ADDR_WIDTH-1:0];
                                state  <= ST_FETCH;
                                halted <= 1'b0;
                            end
                            default: begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                        endcase
                    end
                    ST_WAIT: begin
                        if (wait_met) begin
                            state <= ST_FETCH;
                        end
                        halted <= 1'b0;
                    end
                    default: begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_copper_list_sequencer.sv
// Directed bench for copper_list_sequencer: a 6-bit-address instance for the
// main list tests and a 2-bit-address instance for program counter wrap.
module tb_copper_list_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               vsync_start;
    logic signed [15:0] x;
    logic signed [15:0] y;

    logic [5:0]  prog_addr_a;
    logic [31:0] prog_data_a;
    logic        wr_en_a;
    logic [3:0]  wr_addr_a;
    logic [23:0] wr_data_a;
    logic        halted_a;

    logic [1:0]  prog_addr_b;
    logic [31:0] prog_data_b;
    logic        wr_en_b;
    logic [3:0]  wr_addr_b;
    logic [23:0] wr_data_b;
    logic        halted_b;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) prog_data_a <= mem_a[prog_addr_a];
    always @(posedge clk) prog_data_b <= mem_b[prog_addr_b];

    copper_list_sequencer #(.COORD_WIDTH(16), .ADDR_WIDTH(6), .REG_ADDR_WIDTH(4)) dut_a (
        .pixel_clock(clk), .reset(reset), .enable(enable), .vsync_start(vsync_start),
        .x(x), .y(y), .prog_addr(prog_addr_a), .prog_data(prog_data_a),
        .reg_wr_en(wr_en_a), .reg_wr_addr(wr_addr_a), .reg_wr_data(wr_data_a),
        .halted(halted_a)
    );

    copper_list_sequencer #(.COORD_WIDTH(16), .ADDR_WIDTH(2), .REG_ADDR_WIDTH(4)) dut_b (
        .pixel_clock(clk), .reset(reset), .enable(enable), .vsync_start(vsync_start),
        .x(x), .y(y), .prog_addr(prog_addr_b), .prog_data(prog_data_b),
        .reg_wr_en(wr_en_b), .reg_wr_addr(wr_addr_b), .reg_wr_data(wr_data_b),
        .halted(halted_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] f_move(input logic [3:0] r, input logic [23:0] d);
        return {2'b00, 2'b00, r, d};
    endfunction

    function automatic logic [31:0] f_wait(input logic [11:0] ty, input logic [11:0] tx);
        return {2'b01, 2'b00, ty, 4'h0, tx};
    endfunction

    function automatic logic [31:0] f_jump(input logic [5:0] a);
        return {2'b11, 24'h0, a};
    endfunction

    localparam logic [31:0] END_I = 32'h8000_0000;

    task automatic pulse_vsync();
        vsync_start = 1'b1;
        step();
        vsync_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; vsync_start = 1'b0; x = 16'sd0; y = -16'sd5;
        for (int i = 0; i < 64; i++) mem_a[i] = END_I;
        for (int i = 0; i < 4; i++) mem_b[i] = END_I;
        step(2);
        reset = 1'b0;

        // Reset then idle with no vsync.
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_state", {29'd0, halted_a, wr_en_a, (prog_addr_a != 6'd0)}, 32'd4);
        end
        chk("idle_wr_data", {8'd0, wr_data_a}, 32'd0);

        // MOVE sequence: strobes two cycles apart.
        mem_a[0] = f_move(4'd1, 24'h112255);
        mem_a[1] = f_move(4'd2, 24'h442211);
        mem_a[2] = END_I;
        pulse_vsync();
        chk("mv_halted_run", {31'd0, halted_a}, 32'd0);
        step();
        chk("mv_no_early", {31'd0, wr_en_a}, 32'd0);
        step();
        chk("mv1_en", {31'd0, wr_en_a}, 32'd1);
        chk("mv1_addr", {28'd0, wr_addr_a}, 32'd1);
        chk("mv1_data", {8'd0, wr_data_a}, 32'h112255);
        step();
        chk("mv_gap", {31'd0, wr_en_a}, 32'd0);
        chk("mv_hold_data", {8'd0, wr_data_a}, 32'h112255);
        step();
        chk("mv2_en", {31'd0, wr_en_a}, 32'd1);
        chk("mv2_addr", {28'd0, wr_addr_a}, 32'd2);
        chk("mv2_data", {8'd0, wr_data_a}, 32'h442211);
        step(2);
        chk("mv_end_halted", {31'd0, halted_a}, 32'd1);
        chk("mv_end_pc", {26'd0, prog_addr_a}, 32'd2);
        chk("mv_hold_addr", {28'd0, wr_addr_a}, 32'd2);

        // WAIT on (80,150); negative and not-yet-reached beam positions must not fire.
        mem_a[0] = f_wait(12'd150, 12'd80);
        mem_a[1] = f_move(4'd3, 24'hFFFFFF);
        mem_a[2] = END_I;
        y = -16'sd3; x = 16'sd900;
        pulse_vsync();
        step(2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wt_neg_y", {31'd0, wr_en_a}, 32'd0);
        end
        y = 16'sd200; x = -16'sd2;
        step();
        y = 16'sd149; x = 16'sd900;
        step();
        y = 16'sd150; x = 16'sd79;
        step();
        chk("wt_before", {31'd0, wr_en_a}, 32'd0);
        x = 16'sd80;
        step();
        x = 16'sd81;
        chk("wt_t1", {31'd0, wr_en_a}, 32'd0);
        step();
        x = 16'sd82;
        chk("wt_t2", {31'd0, wr_en_a}, 32'd0);
        step();
        chk("wt_t3_en", {31'd0, wr_en_a}, 32'd1);
        chk("wt_t3_addr", {28'd0, wr_addr_a}, 32'd3);
        chk("wt_t3_data", {8'd0, wr_data_a}, 32'hFFFFFF);
        step(3);
        chk("wt_halted", {31'd0, halted_a}, 32'd1);

        // WAIT (0,0) with beam already past completes after one WAIT cycle.
        mem_a[0] = f_wait(12'd0, 12'd0);
        mem_a[1] = f_move(4'd5, 24'h0A0B0C);
        x = 16'sd10; y = 16'sd20;
        pulse_vsync();
        step(4);
        chk("w0_not_yet", {31'd0, wr_en_a}, 32'd0);
        step();
        chk("w0_en", {31'd0, wr_en_a}, 32'd1);
        chk("w0_data", {8'd0, wr_data_a}, 32'h0A0B0C);
        step(3);

        // vsync during the second MOVE's EXEC: no write, list restarts.
        mem_a[0] = f_move(4'd1, 24'h111111);
        mem_a[1] = f_move(4'd2, 24'h222222);
        mem_a[2] = END_I;
        pulse_vsync();
        step(2);
        chk("ov_first", {28'd0, wr_addr_a}, 32'd1);
        step();
        vsync_start = 1'b1;
        step();
        vsync_start = 1'b0;
        chk("ov_no_strobe", {31'd0, wr_en_a}, 32'd0);
        chk("ov_pc0", {26'd0, prog_addr_a}, 32'd0);
        step(2);
        chk("ov_rerun_en", {31'd0, wr_en_a}, 32'd1);
        chk("ov_rerun_data", {8'd0, wr_data_a}, 32'h111111);
        step(2);
        chk("ov_second", {8'd0, wr_data_a}, 32'h222222);
        step(3);

        // Wrap on the 2-bit instance: four MOVEs, no END.
        for (int i = 0; i < 4; i++) mem_b[i] = f_move(4'(i + 1), 24'(32'hA0 + i));
        pulse_vsync();
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("wrap_en", {31'd0, wr_en_b}, 32'd1);
            chk("wrap_addr", {28'd0, wr_addr_b}, 32'((i % 4) + 1));
            step();
        end

        // MOVE + JUMP 0 loop: one strobe every four cycles.
        mem_a[0] = f_move(4'd6, 24'h123456);
        mem_a[1] = f_jump(6'd0);
        pulse_vsync();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("jmp_en", {31'd0, wr_en_a}, 32'd1);
            for (int k = 0; k < 3; k++) begin
                step();
                chk("jmp_gap", {31'd0, wr_en_a}, 32'd0);
            end
        end
        chk("jmp_data", {8'd0, wr_data_a}, 32'h123456);

        // enable dropped mid-WAIT, restored without vsync: stays idle.
        mem_a[0] = f_wait(12'd100, 12'd0);
        mem_a[1] = f_move(4'd7, 24'h777777);
        mem_a[2] = END_I;
        x = 16'sd5; y = 16'sd50;
        pulse_vsync();
        step(4);
        chk("en_in_wait", {31'd0, halted_a}, 32'd0);
        enable = 1'b0;
        step();
        chk("en_drop_halt", {31'd0, halted_a}, 32'd1);
        enable = 1'b1;
        y = 16'sd200;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("en_no_resume", {30'd0, halted_a, wr_en_a}, 32'd2);
        end
        pulse_vsync();
        step(4);
        chk("en_vs_not_yet", {31'd0, wr_en_a}, 32'd0);
        step();
        chk("en_vs_en", {31'd0, wr_en_a}, 32'd1);
        chk("en_vs_data", {8'd0, wr_data_a}, 32'h777777);

        // reset together with vsync while running.
        mem_a[0] = f_move(4'd6, 24'h123456);
        mem_a[1] = f_jump(6'd0);
        pulse_vsync();
        step(3);
        reset = 1'b1; vsync_start = 1'b1;
        step();
        reset = 1'b0; vsync_start = 1'b0;
        chk("rst_halted", {31'd0, halted_a}, 32'd1);
        chk("rst_en", {31'd0, wr_en_a}, 32'd0);
        chk("rst_addr", {28'd0, wr_addr_a}, 32'd0);
        chk("rst_data", {8'd0, wr_data_a}, 32'd0);
        chk("rst_pc", {26'd0, prog_addr_a}, 32'd0);
        chk("rst_b", {28'd0, halted_b, wr_en_b, prog_addr_b}, 32'h8);
        step(5);
        chk("rst_stays", {30'd0, halted_a, wr_en_a}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
